// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/interlock controller for the 5-stage RV32I pipeline: load-use and RAW
// stalls, branch flush, operand-forward selects and stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int FORWARD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CE,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        ex_branch_taken,
    output logic        id_exe_dstall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // Scoreboard: slot E shadows EXE, slot M shadows MEM. M never needs the
    // load flag because a load in MEM is always forwardable from writeback data.
    logic       e_v, e_ld, m_v;
    logic [4:0] e_rd, m_rd;

    logic hit_e_rs1, hit_e_rs2, hit_m_rs1, hit_m_rs2;
    logic stall, flush, gate;

    function automatic logic [1:0] fwd_sel(input logic hit_e, input logic e_load,
                                           input logic hit_m);
        if (hit_e && !e_load)
            return 2'b01;
        else if (hit_m)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        hit_e_rs1 = e_v & id_rs1_used & (id_rs1 == e_rd);
        hit_e_rs2 = e_v & id_rs2_used & (id_rs2 == e_rd);
        hit_m_rs1 = m_v & id_rs1_used & (id_rs1 == m_rd);
        hit_m_rs2 = m_v & id_rs2_used & (id_rs2 == m_rd);

        if (FORWARD != 0)
            stall = (hit_e_rs1 | hit_e_rs2) & e_ld;
        else
            stall = hit_e_rs1 | hit_e_rs2 | hit_m_rs1 | hit_m_rs2;

        flush = ex_branch_taken;
        gate  = CE & ~rst;

        id_exe_dstall = gate & (stall | flush);
        if_id_stall   = gate & stall & ~flush;
        if_id_flush   = gate & flush;

        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (FORWARD != 0 && gate) begin
            fwd_a_sel = fwd_sel(hit_e_rs1, e_ld, hit_m_rs1);
            fwd_b_sel = fwd_sel(hit_e_rs2, e_ld, hit_m_rs2);
        end
    end

    // Slot advance and event counters; everything freezes while CE is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_v       <= 1'b0;
            e_rd      <= 5'd0;
            e_ld      <= 1'b0;
            m_v       <= 1'b0;
            m_rd      <= 5'd0;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (CE) begin
            m_v  <= e_v;
            m_rd <= e_rd;
            e_v  <= id_reg_write & (id_rd != 5'd0) & ~id_exe_dstall;
            e_rd <= id_rd;
            e_ld <= id_mem_read;
            if (stall && !flush)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: FORWARD=1 and FORWARD=0 instances share
// stimulus and are compared against an in-flight-instruction reference model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ce;
    logic [4:0] rs1, rs2, rd;
    logic       rs1u, rs2u, rw, ld, br;

    logic        d1_dstall, d1_stall, d1_flush;
    logic [1:0]  d1_fa, d1_fb;
    logic [31:0] d1_scnt, d1_fcnt;
    logic        d0_dstall, d0_stall, d0_flush;
    logic [1:0]  d0_fa, d0_fb;
    logic [31:0] d0_scnt, d0_fcnt;

    pipeline_hazard_ctrl #(.FORWARD(1)) dut_fwd (
        .clk(clk), .rst(rst), .CE(ce),
        .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(rs1u), .id_rs2_used(rs2u),
        .id_rd(rd), .id_reg_write(rw), .id_mem_read(ld), .ex_branch_taken(br),
        .id_exe_dstall(d1_dstall), .if_id_stall(d1_stall), .if_id_flush(d1_flush),
        .fwd_a_sel(d1_fa), .fwd_b_sel(d1_fb), .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt)
    );

    pipeline_hazard_ctrl #(.FORWARD(0)) dut_nofwd (
        .clk(clk), .rst(rst), .CE(ce),
        .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(rs1u), .id_rs2_used(rs2u),
        .id_rd(rd), .id_reg_write(rw), .id_mem_read(ld), .ex_branch_taken(br),
        .id_exe_dstall(d0_dstall), .if_id_stall(d0_stall), .if_id_flush(d0_flush),
        .fwd_a_sel(d0_fa), .fwd_b_sel(d0_fb), .stall_cnt(d0_scnt), .flush_cnt(d0_fcnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: per variant k (0 = forwarding, 1 = no forwarding), the instructions
    // in flight in EXE (index 0) and MEM (index 1). dst = -1 means no register result.
    int          pdst[2][2];
    bit          pld [2][2];
    logic [31:0] mscnt[2], mfcnt[2];
    int          ndst[2];
    bit          nld [2];
    bit          nstall[2], nflush[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                pdst[k][s] = -1;
                pld[k][s]  = 1'b0;
            end
            mscnt[k] = 32'd0;
            mfcnt[k] = 32'd0;
        end
    endtask

    function automatic bit reads(input bit used, input logic [4:0] src, input int dst);
        return used && src != 5'd0 && dst == int'(src);
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit fe, a_e, b_e, a_m, b_m, st;
            logic [1:0] ea, eb;
            string p;
            fe  = (k == 0);
            p   = fe ? "fwd" : "nofwd";
            a_e = reads(rs1u, rs1, pdst[k][0]);
            b_e = reads(rs2u, rs2, pdst[k][0]);
            a_m = reads(rs1u, rs1, pdst[k][1]);
            b_m = reads(rs2u, rs2, pdst[k][1]);
            st  = fe ? ((a_e || b_e) && pld[k][0]) : (a_e || b_e || a_m || b_m);
            ea = 2'b00;
            eb = 2'b00;
            if (fe && ce) begin
                ea = (a_e && !pld[k][0]) ? 2'b01 : (a_m ? 2'b10 : 2'b00);
                eb = (b_e && !pld[k][0]) ? 2'b01 : (b_m ? 2'b10 : 2'b00);
            end
            chk({p, "_dstall"}, fe ? d1_dstall : d0_dstall, ce & (st | br));
            chk({p, "_stall"},  fe ? d1_stall  : d0_stall,  ce & st & ~br);
            chk({p, "_flush"},  fe ? d1_flush  : d0_flush,  ce & br);
            chk({p, "_fwd_a"},  fe ? d1_fa : d0_fa, ea);
            chk({p, "_fwd_b"},  fe ? d1_fb : d0_fb, eb);
            chk({p, "_scnt"},   fe ? d1_scnt : d0_scnt, mscnt[k]);
            chk({p, "_fcnt"},   fe ? d1_fcnt : d0_fcnt, mfcnt[k]);
            ndst[k]   = (rw && rd != 5'd0 && !(st || br)) ? int'(rd) : -1;
            nld[k]    = ld;
            nstall[k] = st && !br;
            nflush[k] = br;
        end
    endtask

    task automatic set_in(input bit c, input logic [4:0] a, input bit au,
                          input logic [4:0] b, input bit bu, input logic [4:0] d,
                          input bit w, input bit l, input bit t);
        ce = c; rs1 = a; rs1u = au; rs2 = b; rs2u = bu; rd = d; rw = w; ld = l; br = t;
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        if (ce) begin
            for (int k = 0; k < 2; k++) begin
                pdst[k][1] = pdst[k][0];
                pld[k][1]  = pld[k][0];
                pdst[k][0] = ndst[k];
                pld[k][0]  = nld[k];
                if (nstall[k]) mscnt[k] = mscnt[k] + 32'd1;
                if (nflush[k]) mfcnt[k] = mfcnt[k] + 32'd1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        chk("rst_dstall", {d1_dstall, d0_dstall}, 2'b00);
        chk("rst_stall",  {d1_stall, d0_stall}, 2'b00);
        chk("rst_flush",  {d1_flush, d0_flush}, 2'b00);
        chk("rst_fwd",    {d1_fa, d1_fb}, 4'h0);
        chk("rst_cnt",    d1_scnt | d1_fcnt | d0_scnt | d0_fcnt, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        set_in(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 1);
        do_reset();

        // load x5, then add x6,x5,x1
        set_in(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0); settle(); advance();
        set_in(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); settle();
        chk("lu_dstall", d1_dstall, 1'b1);
        chk("lu_stall", d1_stall, 1'b1);
        advance();
        settle();
        chk("lu_after_stall", d1_stall, 1'b0);
        chk("lu_fwd_a", d1_fa, 2'b10);
        chk("lu_scnt", d1_scnt, 32'd1);
        advance();

        // addi x0,x0,1 then a reader of x0
        set_in(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0); settle(); advance();
        set_in(1, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0); settle();
        chk("x0_dstall", d1_dstall, 1'b0);
        chk("x0_fwd", {d1_fa, d1_fb}, 4'h0);
        advance();

        // addi x7,x0,3 ; sub x8,x7,x7 ; consumer of x7
        set_in(1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 0, 0); settle(); advance();
        set_in(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0); settle();
        chk("alu_dstall", d1_dstall, 1'b0);
        chk("alu_fwd", {d1_fa, d1_fb}, 4'b0101);
        advance();
        set_in(1, 5'd7, 1, 5'd2, 1, 5'd9, 1, 0, 0); settle();
        chk("alu_fwd_m", d1_fa, 2'b10);
        advance();

        // branch taken together with a load-use hazard
        set_in(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0); settle(); advance();
        set_in(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 1); settle();
        chk("br_flush", d1_flush, 1'b1);
        chk("br_dstall", d1_dstall, 1'b1);
        chk("br_stall", d1_stall, 1'b0);
        advance();
        chk("br_fcnt", d1_fcnt, 32'd1);
        chk("br_scnt", d1_scnt, 32'd1);

        // CE low for 3 cycles during a load-use hazard
        set_in(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0); settle(); advance();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); settle();
            chk("ce0_dstall", d1_dstall, 1'b0);
            advance();
        end
        set_in(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); settle();
        chk("ce1_stall", d1_stall, 1'b1);
        advance();
        chk("ce1_scnt", d1_scnt, 32'd2);

        // reset pulse while a hazard is pending
        set_in(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0); settle(); advance();
        set_in(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        do_reset();
        settle();
        chk("postrst_dstall", d1_dstall, 1'b0);
        chk("postrst_cnt", d1_scnt, 32'd0);
        advance();

        // no forwarding: addi x3 ; add x4,x3,x3 stalls two cycles
        set_in(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0); settle(); advance();
        set_in(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("nofwd_stall", d0_stall, (i < 2) ? 1'b1 : 1'b0);
            chk("nofwd_sel", {d0_fa, d0_fb}, 4'h0);
            advance();
        end

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            set_in($urandom_range(0, 7) != 0,
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and interlock controller for the 5-stage RV32I pipeline. It drives the bubble-insert input `ID_EXE_dstall` of the ID/EXE register, the hold and flush controls of PC/IF-ID, and the operand-forwarding selects used in ID. A two-slot scoreboard shadows the instructions in EXE and MEM. It also keeps stall and flush event counters for performance debug.

## Interface
- `FORWARD`, default 1: 1 = forwarding enabled, only load-use stalls; 0 = no forwarding, stall on any RAW hit in EXE or MEM.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `CE` input 1: global pipeline advance enable, shared with the pipeline registers.
- `id_rs1`, `id_rs2` input 5 each: source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` input 1 each: the ID instruction reads rs1 / rs2.
- `id_rd` input 5: destination of the ID instruction.
- `id_reg_write` input 1: the ID instruction writes `id_rd`.
- `id_mem_read` input 1: the ID instruction is a load.
- `ex_branch_taken` input 1: the EXE instruction redirects the PC this cycle.
- `id_exe_dstall` output 1: insert a bubble into ID/EXE. Connects to `ID_EXE_dstall`.
- `if_id_stall` output 1: hold the PC and the IF/ID register.
- `if_id_flush` output 1: replace IF/ID contents with NOP (0x00000013).
- `fwd_a_sel`, `fwd_b_sel` output 2 each: operand source select. 00 = register file, 01 = EXE ALU result, 10 = MEM-stage writeback data.
- `stall_cnt` output 32: count of load-use/RAW stall cycles.
- `flush_cnt` output 32: count of branch flush cycles.

## Operation
- Scoreboard slots E (EXE) and M (MEM). Each slot holds `v`, `rd[4:0]`, `ld`.
  - `v` is set only if the producer has `reg_write=1` and `rd != 0`.
- Match rule: `hitX_rsN = X.v & id_rsN_used & (id_rsN == X.rd)`. x0 never matches.
- Stall condition, FORWARD=1: `stall = (hitE_rs1 | hitE_rs2) & E.ld`.
- Stall condition, FORWARD=0: `stall = any hitE | any hitM`.
  - The register file is write-first, so a producer in WB needs no stall.
- Flush: `flush = ex_branch_taken`. Flush has priority over stall.
- Outputs are combinational and gated by CE and rst. When `CE=0` or `rst=1`, all control outputs are 0.
  - `id_exe_dstall = CE & (stall | flush)`.
  - `if_id_stall = CE & stall & ~flush`.
  - `if_id_flush = CE & flush`.
- Forward selects (FORWARD=1 only; constant 00 when FORWARD=0):
  - 01 if hitE on that operand and `~E.ld`.
  - Otherwise 10 if hitM on that operand.
  - Otherwise 00.
  - The youngest producer (E) wins over M.
- Scoreboard update on posedge clk with `CE=1`:
  - M <= E.
  - E <= {`id_reg_write & (id_rd != 0) & ~id_exe_dstall`, `id_rd`, `id_mem_read`}.
  - A bubble therefore enters E as invalid.
- With `CE=0`, the slots and counters hold.
- Counters, on posedge clk with `CE=1`:
  - `stall_cnt` increments when `stall & ~flush`.
  - `flush_cnt` increments when `flush`.
  - Both wrap modulo 2^32.

## Timing
- Reset (async) clears E and M to `v=0`, `rd=0`, `ld=0`, and sets both counters to 0.
  - While rst is high, all outputs read 0.
  - After deassertion, outputs are 0 until a producer enters the scoreboard.
- Zero-latency control: stall, flush and forward selects reflect the current-cycle inputs and slot state.
- A load-use stall lasts exactly 1 CE cycle with FORWARD=1.
  - After the bubble, the load sits in M and the consumer gets `fwd_sel=10`.
- With FORWARD=0, a producer immediately ahead stalls for 2 CE cycles; one two ahead stalls for 1.
- Branch taken while a stall is pending: flush wins.
  - `if_id_stall=0`, the ID instruction is killed, and `stall_cnt` does not increment.
- `CE=0` mid-stall: outputs drop to 0 and state freezes. The stall resumes when `CE` returns.
- Reset mid-stall drops all slots. No stall follows.

## Test plan
- Load x5 in ID, then `add x6,x5,x1` (FORWARD=1) -> one cycle with `id_exe_dstall=1`, `if_id_stall=1`. Next cycle `fwd_a_sel=10`. `stall_cnt` = 1.
- ALU `addi x7,x0,3`, then immediately `sub x8,x7,x7` -> no stall; `fwd_a_sel=fwd_b_sel=01`. One instruction later, a consumer of x7 sees 10.
- Producer writes x0 (`addi x0,x0,1`) followed by a reader of x0 -> no stall; selects 00.
- FORWARD=0, `addi x3,...`, then `add x4,x3,x3` -> `if_id_stall=1` for exactly 2 cycles; selects stay 00.
- `ex_branch_taken=1` coinciding with a load-use hazard -> `if_id_flush=1`, `id_exe_dstall=1`, `if_id_stall=0`. `flush_cnt` = 1, `stall_cnt` unchanged.
- `CE=0` for 3 cycles during a load-use hazard, then a mid-sequence rst pulse -> outputs 0 while CE low. Hazard reasserts for 1 cycle after CE returns. After rst, slots are empty and counters are 0.
